// File: rtl/axi_pkg.sv
// Shared AXI encodings, the 4 KB burst boundary and the read-DMA state enumeration.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned BOUNDARY_4K = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry stream buffer carrying data+last; upstream ready comes straight from a flop.
module axis_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i
);
    logic [DATA_WIDTH:0] mem_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          cnt_q;
    logic [1:0]          cnt_d;
    logic                full_q;
    logic                push;
    logic                pop;

    assign push      = s_valid_i && !full_q;
    assign pop       = m_valid_o && m_ready_i;
    assign cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    assign s_ready_o = !full_q;
    assign m_valid_o = (cnt_q != 2'd0);
    assign {m_last_o, m_data_o} = m_valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q ^ push;
            rd_ptr_q <= rd_ptr_q ^ pop;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_last_i, s_data_i};
    end

endmodule

// File: rtl/axi_rd_dma.sv
// AXI4 read DMA: splits one command into 4 KB-safe INCR bursts, one outstanding at a time.
// Define AXI_RD_DMA_PERF_EN to add the perf_stall_cnt output.
module axi_rd_dma
    import axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 16,
    parameter int STRB_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH      = 8,
    parameter int AXI_ID        = 0,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [15:0]           cmd_beats,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
`ifdef AXI_RD_DMA_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt
`endif
);
    localparam int SH = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    rd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           rem_q, rem_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;

    logic [12:0] to_bnd;
    logic [16:0] blen;
    logic [7:0]  arlen_c;
    logic [16:0] burst_beats;
    logic        burst_end;
    logic        cmd_end;
    logic        r_hs;
    logic        sk_ready;
    logic        sk_valid;
    logic        unused_rid;

    assign unused_rid = ^m_axi_rid;

    // Beats available before the 4 KB line ends; addr_q is beat-aligned so the shift is exact.
    always_comb begin
        to_bnd = 13'(BOUNDARY_4K) - {1'b0, addr_q[11:0]};
        blen   = {1'b0, rem_q};
        if (blen > 17'(MAX_BURST_LEN)) blen = 17'(MAX_BURST_LEN);
        if (blen > 17'(to_bnd >> SH))  blen = 17'(to_bnd >> SH);
        arlen_c = 8'(blen - 17'd1);
    end

    assign burst_beats = 17'(len_q) + 17'd1;
    assign burst_end   = (beat_q == len_q);
    assign cmd_end     = burst_end && ({1'b0, rem_q} == burst_beats);
    assign r_hs        = m_axi_rvalid && m_axi_rready;

    assign cmd_ready     = !rst && (state_q == ST_IDLE);
    assign busy          = !rst && ((state_q == ST_ADDR) || (state_q == ST_DATA));
    assign done          = !rst && (state_q == ST_DONE);
    assign err           = done && err_q;
    assign m_axi_arvalid = !rst && (state_q == ST_ADDR);
    assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
    assign m_axi_arlen   = m_axi_arvalid ? arlen_c : '0;
    assign m_axi_arid    = rst ? '0 : ID_WIDTH'(AXI_ID);
    assign m_axi_arsize  = rst ? '0 : 3'(SH);
    assign m_axi_arburst = rst ? '0 : BURST_INCR;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = rst ? '0 : 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = !rst && (state_q == ST_DATA) && sk_ready;
    assign m_axis_tvalid = !rst && sk_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready) begin
                addr_d  = cmd_addr & ALIGN_MASK;
                rem_d   = cmd_beats;
                err_d   = 1'b0;
                state_d = (cmd_beats == 16'd0) ? ST_DONE : ST_ADDR;
            end
            ST_ADDR: if (m_axi_arready) begin
                len_d   = arlen_c;
                beat_d  = '0;
                state_d = ST_DATA;
            end
            // The local beat count ends the burst; rlast is only cross-checked.
            ST_DATA: if (r_hs) begin
                if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != burst_end)) err_d = 1'b1;
                if (burst_end) begin
                    addr_d  = addr_q + ADDR_WIDTH'({7'd0, burst_beats} << SH);
                    rem_d   = rem_q - burst_beats[15:0];
                    state_d = cmd_end ? ST_DONE : ST_ADDR;
                end else begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

    axis_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (m_axi_rdata),
        .s_last_i  (cmd_end),
        .s_valid_i (r_hs),
        .s_ready_o (sk_ready),
        .m_data_o  (m_axis_tdata),
        .m_last_o  (m_axis_tlast),
        .m_valid_o (sk_valid),
        .m_ready_i (m_axis_tready)
    );

`ifdef AXI_RD_DMA_PERF_EN
    logic [31:0] perf_cnt_q;
    logic        stall;

    assign stall = ((state_q == ST_ADDR) || (state_q == ST_DATA)) &&
                   ((m_axi_arvalid && !m_axi_arready) || (m_axi_rvalid && !m_axi_rready));

    always_ff @(posedge clk) begin
        if (rst)                                          perf_cnt_q <= '0;
        else if ((state_q == ST_IDLE) && cmd_valid)       perf_cnt_q <= '0;
        else if (stall && (perf_cnt_q != 32'hFFFF_FFFF))  perf_cnt_q <= perf_cnt_q + 32'd1;
    end

    assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_axi_rd_dma.sv
// Directed bench for axi_rd_dma with a behavioural AXI read responder (rdata = {16'hC0DE, addr}).
module tb_axi_rd_dma;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_beats = '0;
    logic        done, err, busy;
    logic [31:0] tdata;
    logic        tvalid, tlast;
    logic        tready = 1'b1;
    logic [7:0]  arid;
    logic [15:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [7:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;
`ifdef AXI_RD_DMA_PERF_EN
    logic [31:0] perf_unused;
`endif

    always #5 clk = ~clk;

    axi_rd_dma dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .done(done), .err(err), .busy(busy),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast),
        .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache), .m_axi_arprot(arprot),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
        .m_axi_rvalid(rvalid), .m_axi_rready(rready)
`ifdef AXI_RD_DMA_PERF_EN
        , .perf_stall_cnt(perf_unused)
`endif
    );

    int checks = 0;
    int passes = 0;

    // stimulus knobs (written only by the main initial block)
    bit          ar_rand = 0, r_rand = 0, tr_rand = 0, bad_rlast = 0;
    logic [15:0] err_addr = 16'hFFFF;

    // monitor state (written only by the negedge monitor)
    logic [31:0] s_data_log [1024];
    logic        s_last_log [1024];
    logic [15:0] ar_a [128];
    logic [7:0]  ar_l [128];
    int s_cnt = 0, ar_cnt = 0, done_cnt = 0, r_tot = 0, s_tot = 0;
    int full_bad = 0, lat_bad = 0, const_bad = 0;
    logic done_err = 1'b0;
    bit ar_hs_f = 0, r_hs_f = 0, pend_push = 0;

    always @(negedge clk) begin
        if (rst) begin
            ar_hs_f = 0; r_hs_f = 0; pend_push = 0; r_tot = s_tot;
        end else begin
            if (rready && (r_tot - s_tot) >= 2) full_bad++;
            if ((r_tot - s_tot) > 2) full_bad++;
            if (pend_push && !tvalid) lat_bad++;
            ar_hs_f = arvalid && arready;
            r_hs_f  = rvalid && rready;
            pend_push = r_hs_f;
            if (r_hs_f) r_tot++;
            if (ar_hs_f) begin
                if (arsize != 3'd2 || arburst != 2'b01 || arid != 8'd0 || arcache != 4'b0011 ||
                    arlock != 1'b0 || arprot != 3'd0) const_bad++;
                ar_a[ar_cnt] = araddr; ar_l[ar_cnt] = arlen; ar_cnt++;
            end
            if (tvalid && tready) begin
                s_data_log[s_cnt] = tdata; s_last_log[s_cnt] = tlast; s_cnt++; s_tot++;
            end
            if (done) begin done_cnt++; done_err = err; end
        end
    end

    // Responder: one burst at a time, rvalid held until accepted.
    logic [15:0] rb_addr = '0;
    int          rb_left = 0;
    bit          rb_act = 0;
    always @(posedge clk) begin
        #2;
        if (rst) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rb_act = 0;
        end else begin
            if (r_hs_f) begin
                rb_left--; rb_addr += 16'd4;
                if (rb_left == 0) rb_act = 0;
            end
            if (ar_hs_f) begin
                rb_act = 1; rb_addr = ar_a[ar_cnt-1]; rb_left = int'(ar_l[ar_cnt-1]) + 1;
            end
            arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!(rvalid && !r_hs_f)) begin
                rvalid = rb_act && (!r_rand || $urandom_range(0, 1) == 1);
                rdata  = {16'hC0DE, rb_addr};
                rresp  = (rb_addr == err_addr) ? 2'b10 : 2'b00;
                rlast  = (rb_left == 1) && !bad_rlast;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        tready = tr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_cmd(input logic [15:0] a, input logic [15:0] n);
        int k = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_addr = a; cmd_beats = n;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        chk("cmd_accept", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Runs one command to completion and checks count, order, data, tlast and err.
    task automatic do_cmd(input string tag, input logic [15:0] a, input logic [15:0] n, input logic exp_err);
        int d0 = done_cnt;
        int s0 = s_cnt;
        int k = 0;
        int data_bad = 0;
        int last_bad = 0;
        logic [15:0] ea;
        send_cmd(a, n);
        while (!(done_cnt > d0 && s_cnt >= s0 + int'(n)) && k < 3000) begin @(negedge clk); k++; end
        chk({tag, "_timeout"}, k < 3000, 1'b1);
        repeat (4) @(negedge clk);
        chk({tag, "_beats"}, s_cnt - s0, n);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_err"}, done_err, exp_err);
        for (int i = 0; i < int'(n); i++) begin
            ea = a + 16'(4 * i);
            if (s_data_log[s0 + i] !== {16'hC0DE, ea}) data_bad++;
            if (s_last_log[s0 + i] !== (i == int'(n) - 1)) last_bad++;
        end
        chk({tag, "_data_bad"}, data_bad, 0);
        chk({tag, "_tlast_bad"}, last_bad, 0);
    endtask

    task automatic chk_ar(input string tag, input int idx, input logic [15:0] a, input logic [7:0] l);
        chk(tag, {ar_a[idx], ar_l[idx]}, {a, l});
    endtask

    initial begin
        int a0, r0, d0, k;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1'b1);

        // 1: single burst, arvalid the cycle after accept
        a0 = ar_cnt;
        send_cmd(16'h0100, 16'd4);
        chk("t1_arvalid_latency", arvalid, 1'b1);
        chk("t1_busy", busy, 1'b1);
        d0 = done_cnt; k = 0;
        while (!(done_cnt > d0 && s_cnt >= 4) && k < 500) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        chk("t1_ar_count", ar_cnt - a0, 1);
        chk_ar("t1_ar0", a0, 16'h0100, 8'd3);
        chk("t1_beats", s_cnt, 4);
        chk("t1_data0", s_data_log[0], 32'hC0DE_0100);
        chk("t1_data3", s_data_log[3], 32'hC0DE_010C);
        chk("t1_tlast", {s_last_log[0], s_last_log[1], s_last_log[2], s_last_log[3]}, 4'b0001);
        chk("t1_err", done_err, 1'b0);
        chk("t1_ar_consts", const_bad, 0);

        // 2: 40 beats -> 16 + 16 + 8
        a0 = ar_cnt;
        do_cmd("t2", 16'h0000, 16'd40, 1'b0);
        chk("t2_ar_count", ar_cnt - a0, 3);
        chk_ar("t2_ar0", a0,     16'h0000, 8'd15);
        chk_ar("t2_ar1", a0 + 1, 16'h0040, 8'd15);
        chk_ar("t2_ar2", a0 + 2, 16'h0080, 8'd7);

        // 3: 4 KB split
        a0 = ar_cnt;
        do_cmd("t3", 16'h0FF8, 16'd4, 1'b0);
        chk("t3_ar_count", ar_cnt - a0, 2);
        chk_ar("t3_ar0", a0,     16'h0FF8, 8'd1);
        chk_ar("t3_ar1", a0 + 1, 16'h1000, 8'd1);

        // 4: random backpressure everywhere
        ar_rand = 1; r_rand = 1; tr_rand = 1;
        a0 = ar_cnt;
        do_cmd("t4", 16'h2FC0, 16'd64, 1'b0);
        ar_rand = 0; r_rand = 0; tr_rand = 0;
        chk("t4_ar_count", ar_cnt - a0, 4);
        chk_ar("t4_ar0", a0,     16'h2FC0, 8'd15);
        chk_ar("t4_ar3", a0 + 3, 16'h3080, 8'd15);
        chk("t4_rready_when_full", full_bad, 0);
        chk("t4_tvalid_latency", lat_bad, 0);

        // 5: SLVERR on beat 2 is sticky for that command only
        err_addr = 16'h0204;
        do_cmd("t5_slverr", 16'h0200, 16'd4, 1'b1);
        err_addr = 16'hFFFF;
        do_cmd("t5_okay", 16'h0300, 16'd4, 1'b0);
        bad_rlast = 1;
        do_cmd("t5_no_rlast", 16'h0400, 16'd2, 1'b1);
        bad_rlast = 0;
        do_cmd("t5_okay2", 16'h0500, 16'd3, 1'b0);

        // 6: reset in the middle of DATA
        r0 = r_tot;
        send_cmd(16'h0800, 16'd16);
        k = 0;
        while (r_tot < r0 + 5 && k < 500) begin @(negedge clk); k++; end
        chk("t6_reached_data", k < 500, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_rst_arvalid", arvalid, 1'b0);
        chk("t6_rst_tvalid", tvalid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_rready", rready, 1'b0);
        chk("t6_rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_release_cmd_ready", cmd_ready, 1'b1);

        // zero-beat command: done without AR traffic
        a0 = ar_cnt; d0 = done_cnt;
        send_cmd(16'h0600, 16'd0);
        k = 0;
        while (done_cnt == d0 && k < 50) begin @(negedge clk); k++; end
        repeat (4) @(negedge clk);
        chk("t6_zero_done", done_cnt - d0, 1);
        chk("t6_zero_err", done_err, 1'b0);
        chk("t6_zero_no_ar", ar_cnt - a0, 0);

        do_cmd("t7_after_rst", 16'h0A00, 16'd5, 1'b0);
        chk("final_rready_when_full", full_bad, 0);
        chk("final_tvalid_latency", lat_bad, 0);
        chk("final_ar_consts", const_bad, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_dma.md
Name: axi_rd_dma

Overview:
AXI4 read initiator (master). Turns one command (start address, beat count) into a sequence of INCR read bursts, and returns the read data as a streaming output with a command-level last flag. It pairs with the team's AXI RAM responder. It is the read-side engine for frame/buffer fetch out of on-chip or DDR memory.

Parameters:
DATA_WIDTH, 32, AXI/stream data width in bits; power of two, at least 8.
ADDR_WIDTH, 16, AXI address width; at least 12.
STRB_WIDTH, DATA_WIDTH/8, bytes per beat.
ID_WIDTH, 8, AXI ID width.
AXI_ID, 0, constant value driven on arid.
MAX_BURST_LEN, 16, maximum beats per burst; range 1..256.

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_addr  in  ADDR_WIDTH  start byte address; low log2(STRB_WIDTH) bits ignored (forced 0)
cmd_beats  in  16  total beats to read
done  out  1  one-cycle pulse when the command has completed
err  out  1  valid with done; 1 = any non-OKAY rresp or rlast mismatch
busy  out  1  command in progress
m_axis_tdata  out  DATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  final beat of the command
m_axi_arid  out  ID_WIDTH  equals AXI_ID
m_axi_araddr  out  ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arsize  out  3  log2(STRB_WIDTH), constant
m_axi_arburst  out  2  2'b01 INCR, constant
m_axi_arlock/arcache/arprot  out  1/4/3  constants 0/4'b0011/3'b000
m_axi_arvalid  out  1  address valid
m_axi_arready  in  1  address ready
m_axi_rid  in  ID_WIDTH  ignored
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  burst last
m_axi_rvalid  in  1  read valid
m_axi_rready  out  1  read ready

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. All outputs are 0 during reset, including cmd_ready. In the first cycle after reset release, cmd_ready=1.
- Reset mid-operation: state returns to IDLE on the next edge. arvalid, tvalid and busy drop, and the skid buffer is flushed. In-flight R beats are not drained; the system resets the responder together with this block.
- States:
  - IDLE: cmd_ready=1. On handshake, latch addr and beats, set busy, clear the sticky error, go to ADDR. If cmd_beats==0, go to DONE with no AXI traffic.
  - ADDR: arvalid=1 starting the cycle after entry. araddr, arvalid and arlen are stable until arready. On handshake go to DATA.
  - DATA: accept R beats into the skid buffer. On the burst's final beat: addr += (len+1)*STRB_WIDTH and remaining -= len+1. If remaining>0 go to ADDR, otherwise go to DONE.
  - DONE: single cycle. Assert done and err, deassert busy, go to IDLE with cmd_ready=1.
- Burst length (beats) = min(remaining, MAX_BURST_LEN, (4096 - addr[11:0]) >> log2(STRB_WIDTH)). A burst never crosses a 4 KB boundary. Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Only one burst is outstanding at a time. The next AR is issued no earlier than 1 cycle after the previous burst's last R handshake.
- R path:
  - rready = (state==DATA) && skid buffer not full.
  - Beats are forwarded in order and without loss under any tready pattern.
  - tlast=1 only on the command's final beat, not on intermediate burst ends.
- Errors:
  - rresp != OKAY sets sticky err; the data is still forwarded.
  - rlast=1 before the expected final beat, or rlast=0 on the expected final beat, also sets err. The beat counter, not rlast, decides the end of the burst.
- Latency: cmd handshake at cycle T gives arvalid at T+1. The first beat appears on tvalid 1 cycle after its R handshake.

Optional Feature:
AXI_RD_DMA_PERF_EN.
- Defined: adds output perf_stall_cnt [31:0]. It clears on command accept and increments each cycle with state in {ADDR, DATA} and (arvalid&&!arready or rvalid&&!rready). It saturates at 0xFFFFFFFF and holds its value after done.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package axi_pkg holds:
  - burst encodings FIXED/INCR/WRAP
  - resp encodings OKAY/EXOKAY/SLVERR/DECERR
  - the axi_rd_dma state enumeration
  - the 4 KB boundary constant
- Sub-module axis_skid_buf: 2-entry skid buffer (data+last) with registered ready, reused for stream outputs elsewhere.

Test Plan:
1. cmd addr 0x0100, beats 4, MAX_BURST_LEN 16 -> one AR: araddr 0x0100, arlen 3, arsize 2, arburst 01; 4 stream beats with tlast on the 4th; done with err=0.
2. addr 0x0000, beats 40 -> ARs (0x0000,len15), (0x0040,len15), (0x0080,len7); tlast only on beat 40.
3. addr 0x0FF8, beats 4 -> ARs (0x0FF8,len1), (0x1000,len1); data order preserved.
4. beats 64 with random 50% tready and random arready delay -> data matches RAM contents in order; rready low while the skid buffer is full; no beat dropped or duplicated.
5. SLVERR on beat 2 of 4 -> all 4 beats delivered, done with err=1; next command with OKAY responses -> err=0.
6. rst asserted during DATA of a 16-beat read -> next cycle arvalid=0, tvalid=0, busy=0; cmd_ready=1 the cycle after release. Separately, cmd_beats=0 -> done with no arvalid.
